// File: rtl/setup_hold_sweeper_pkg.sv
// Shared definitions for the setup/hold sweeper: controller states and the
// default width of timing fields and result counters.
package setup_hold_sweeper_pkg;

  localparam int unsigned SHS_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOW    = 3'd1,
    ST_HIGH   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } shs_state_e;

endpackage

// File: rtl/setup_hold_sweeper_gate_cycle_counter.sv
// Loadable down-counter that times the LOW and HIGH phases of each trial.
// A load presents (width-1); the phase ends in the cycle where o_zero is high.
module gate_cycle_counter
  import setup_hold_sweeper_pkg::*;
#(
  parameter int W = SHS_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_L,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_count,
  output logic         o_zero
);

  localparam logic [W-1:0] ZERO_W = {W{1'b0}};
  localparam logic [W-1:0] ONE_W  = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_count;

  // Load on phase entry, otherwise count down and rest at zero.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_count <= ZERO_W;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != ZERO_W) begin
      r_count <= r_count - ONE_W;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == ZERO_W);

endmodule

// File: rtl/setup_hold_sweeper.sv
// Setup/hold sweeper: drives a latch under test through th trials, shrinking
// the data-to-gate-fall offset each trial, and tallies which offsets capture.
module setup_hold_sweeper
  import setup_hold_sweeper_pkg::*;
#(
  parameter int W = SHS_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_L,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] cfg_th,
  input  logic [W-1:0] cfg_tl,
  input  logic         q,
  output logic         g,
  output logic         d,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] pass_cnt,
  output logic [W-1:0] fail_cnt,
  output logic [W-1:0] min_pass_off
);

  localparam logic [W-1:0] ZERO_W = {W{1'b0}};
  localparam logic [W-1:0] ONE_W  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] ALL1_W = {W{1'b1}};

  shs_state_e   r_state, w_state_nx;
  logic [W-1:0] r_th, r_tl, r_off, r_pass, r_fail, r_min;
  logic         r_exp, r_g, r_d, r_busy, r_done;
  logic [W-1:0] w_th_cap, w_tl_cap, w_cnt, w_cnt_load_val, w_k_nx;
  logic         w_cnt_load, w_cnt_zero, w_start_go, w_sample_go, w_match;

  gate_cycle_counter #(.W(W)) u_gate_cycle_counter (
    .clk        (clk),
    .reset_L    (reset_L),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .o_count    (w_cnt),
    .o_zero     (w_cnt_zero)
  );

  assign w_th_cap    = (cfg_th == ZERO_W) ? ONE_W : cfg_th;
  assign w_tl_cap    = (cfg_tl == ZERO_W) ? ONE_W : cfg_tl;
  // HIGH-phase index k of the coming cycle, so d can be registered in step with g.
  assign w_k_nx      = w_cnt_load ? w_cnt_load_val : (w_cnt - ONE_W);
  assign w_start_go  = (r_state == ST_IDLE) && (w_state_nx == ST_LOW);
  assign w_sample_go = (r_state == ST_SAMPLE) && !abort;
  assign w_match     = (q == r_exp);

  // State register.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state and phase-counter load decode; abort overrides everything.
  always_comb begin
    w_state_nx     = r_state;
    w_cnt_load     = 1'b0;
    w_cnt_load_val = ZERO_W;
    if (abort) begin
      w_state_nx = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_state_nx     = ST_LOW;
            w_cnt_load     = 1'b1;
            w_cnt_load_val = w_tl_cap - ONE_W;
          end else begin
            w_state_nx = ST_IDLE;
          end
        end
        ST_LOW: begin
          if (w_cnt_zero) begin
            w_state_nx     = ST_HIGH;
            w_cnt_load     = 1'b1;
            w_cnt_load_val = r_th - ONE_W;
          end else begin
            w_state_nx = ST_LOW;
          end
        end
        ST_HIGH: begin
          if (w_cnt_zero) begin
            w_state_nx = ST_SAMPLE;
          end else begin
            w_state_nx = ST_HIGH;
          end
        end
        ST_SAMPLE: begin
          if (r_off == ZERO_W) begin
            w_state_nx = ST_DONE;
          end else begin
            w_state_nx     = ST_LOW;
            w_cnt_load     = 1'b1;
            w_cnt_load_val = r_tl - ONE_W;
          end
        end
        ST_DONE: w_state_nx = ST_IDLE;
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  // Registered drives and the per-trial datapath (shadows, offset, tallies).
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_g    <= 1'b0;
      r_d    <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_th   <= ZERO_W;
      r_tl   <= ZERO_W;
      r_off  <= ZERO_W;
      r_exp  <= 1'b0;
      r_pass <= ZERO_W;
      r_fail <= ZERO_W;
      r_min  <= ALL1_W;
    end else begin
      r_g    <= (w_state_nx == ST_HIGH);
      r_busy <= (w_state_nx != ST_IDLE);
      r_done <= (w_state_nx == ST_DONE);
      if ((w_state_nx == ST_HIGH) && (w_k_nx <= r_off)) begin
        r_d <= r_exp;
      end
      if (w_start_go) begin
        r_th   <= w_th_cap;
        r_tl   <= w_tl_cap;
        r_off  <= w_th_cap - ONE_W;
        r_exp  <= ~r_d;
        r_pass <= ZERO_W;
        r_fail <= ZERO_W;
        r_min  <= ALL1_W;
      end else if (w_sample_go) begin
        if (w_match) begin
          r_pass <= (r_pass == ALL1_W) ? r_pass : (r_pass + ONE_W);
          r_min  <= r_off;
        end else begin
          r_fail <= (r_fail == ALL1_W) ? r_fail : (r_fail + ONE_W);
        end
        if (r_off != ZERO_W) begin
          r_off <= r_off - ONE_W;
          r_exp <= ~r_exp;
        end
      end
    end
  end

  assign g            = r_g;
  assign d            = r_d;
  assign busy         = r_busy;
  assign done         = r_done;
  assign pass_cnt     = r_pass;
  assign fail_cnt     = r_fail;
  assign min_pass_off = r_min;

endmodule

// File: tb/tb_setup_hold_sweeper.sv
// Directed bench for setup_hold_sweeper with a latch model (ideal or with q
// delayed two cycles) and a scoreboard of per-sweep expected results.
module tb_setup_hold_sweeper;
  import setup_hold_sweeper_pkg::*;

  localparam int W = SHS_W_DEFAULT;
  localparam logic [W-1:0] ONE_W = {{(W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [W-1:0] pass_n;
    logic [W-1:0] fail_n;
    logic [W-1:0] min_off;
    logic [15:0]  cycles;
    logic [15:0]  g_high;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_L, start, abort, q, g, d, busy, done;
  logic [W-1:0] cfg_th, cfg_tl, pass_cnt, fail_cnt, min_pass_off;
  logic         lat_q, q_d1, q_d2, lag_mode;
  int           checks = 0;
  int           errors = 0;
  exp_t         sb_q[$];

  setup_hold_sweeper #(.W(W)) dut (
    .clk(clk), .reset_L(reset_L), .start(start), .abort(abort),
    .cfg_th(cfg_th), .cfg_tl(cfg_tl), .q(q), .g(g), .d(d),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .min_pass_off(min_pass_off)
  );

  always #5 clk = ~clk;

  // Latch under test: transparent while g is high, optional two-flop output lag.
  always_latch begin
    if (g) lat_q <= d;
  end
  always_ff @(posedge clk) begin
    q_d1 <= lat_q;
    q_d2 <= q_d1;
  end
  assign q = lag_mode ? q_d2 : lat_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Trial at offset off passes when d has been stable long enough to cover the q lag.
  function automatic exp_t model(input int th, input int tl, input int lag);
    exp_t r;
    int thc, tlc;
    thc = (th == 0) ? 1 : th;
    tlc = (tl == 0) ? 1 : tl;
    r.pass_n = '0;
    r.fail_n = '0;
    r.min_off = {W{1'b1}};
    for (int off = thc - 1; off >= 0; off--) begin
      if (off + 1 >= lag) begin
        r.pass_n = r.pass_n + ONE_W;
        r.min_off = W'(off);
      end else begin
        r.fail_n = r.fail_n + ONE_W;
      end
    end
    r.cycles = 16'(thc * (tlc + thc + 1));
    r.g_high = 16'(thc * thc);
    return r;
  endfunction

  task automatic run_sweep(input int th, input int tl, input int lag, input bit mid_start);
    exp_t e;
    int n, gh;
    bit got;
    lag_mode = (lag != 0);
    cfg_th = W'(th);
    cfg_tl = W'(tl);
    sb_q.push_back(model(th, tl, lag));
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    n = 0; gh = 0; got = 1'b0;
    while (!got && n < 3000) begin
      start = (mid_start && n == 10);
      step();
      n++;
      if (done) got = 1'b1;
      else if (g) gh++;
    end
    start = 1'b0;
    check("done_seen", 32'(got), 32'd1);
    check("sb_nonempty", 32'(sb_q.size()), 32'd1);
    e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
    check("done_latency", 32'(n), 32'(e.cycles));
    check("g_high_cycles", 32'(gh), 32'(e.g_high));
    check("busy_in_done", 32'(busy), 32'd1);
    check("pass_cnt", 32'(pass_cnt), 32'(e.pass_n));
    check("fail_cnt", 32'(fail_cnt), 32'(e.fail_n));
    check("min_pass_off", 32'(min_pass_off), 32'(e.min_off));
    step();
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
    repeat (3) step();
    check("pass_cnt_hold", 32'(pass_cnt), 32'(e.pass_n));
    check("min_pass_off_hold", 32'(min_pass_off), 32'(e.min_off));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int rises, n;
    bit prev_g, done_seen;
    reset_L = 1'b0; start = 1'b0; abort = 1'b0; lag_mode = 1'b0;
    cfg_th = '0; cfg_tl = '0;
    repeat (2) step();
    check("rst_g", 32'(g), 32'd0);
    check("rst_d", 32'(d), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass_cnt), 32'd0);
    check("rst_fail", 32'(fail_cnt), 32'd0);
    check("rst_min", 32'(min_pass_off), 32'hFF);
    reset_L = 1'b1;
    step();

    run_sweep(4, 3, 0, 1'b0);
    run_sweep(4, 3, 2, 1'b0);
    run_sweep(0, 0, 0, 1'b0);
    run_sweep(5, 2, 2, 1'b1);

    // start and abort together in IDLE: abort wins.
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("startabort_busy", 32'(busy), 32'd0);
    step();
    check("startabort_g", 32'(g), 32'd0);
    check("startabort_busy2", 32'(busy), 32'd0);

    // Abort in the second HIGH phase.
    lag_mode = 1'b0; cfg_th = 8'd4; cfg_tl = 8'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    rises = 0; prev_g = 1'b0; n = 0;
    while (rises < 2 && n < 200) begin
      step();
      n++;
      if (g && !prev_g) rises++;
      prev_g = g;
    end
    check("abort_reach_high2", 32'(rises), 32'd2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_g", 32'(g), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_pass", 32'(pass_cnt), 32'd1);
    check("abort_fail", 32'(fail_cnt), 32'd0);
    done_seen = 1'b0;
    repeat (40) begin
      step();
      if (done) done_seen = 1'b1;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    check("abort_stays_idle", 32'(busy), 32'd0);

    // Reset pulse between edges in the middle of LOW.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("pre_reset_busy", 32'(busy), 32'd1);
    #2 reset_L = 1'b0;
    #1;
    check("mid_rst_g", 32'(g), 32'd0);
    check("mid_rst_d", 32'(d), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_pass", 32'(pass_cnt), 32'd0);
    check("mid_rst_min", 32'(min_pass_off), 32'hFF);
    #1 reset_L = 1'b1;
    step();
    check("post_rst_idle", 32'(busy), 32'd0);
    run_sweep(3, 1, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/setup_hold_sweeper.md
SETUP_HOLD_SWEEPER -- requirements
Module: setup_hold_sweeper

Interface
REQ-001 The block SHALL have parameter W, default 8, setting the width of timing fields and counters.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_L  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
REQ-005 abort  input  1  synchronous cancel of a running sweep.
REQ-006 cfg_th  input  W  gate-high width in cycles.
REQ-007 cfg_tl  input  W  gate-low width in cycles.
REQ-008 q  input  1  latch output under test.
REQ-009 g  output  1  latch enable drive.
REQ-010 d  output  1  latch data drive.
REQ-011 busy  output  1  high while a sweep runs.
REQ-012 done  output  1  one-cycle pulse at sweep completion.
REQ-013 pass_cnt, fail_cnt  output  W each  trial result counters, saturating at all-ones.
REQ-014 min_pass_off  output  W  smallest passing offset; all-ones when no trial has passed.

Function
REQ-015 States SHALL be IDLE, LOW, HIGH, SAMPLE, DONE.
REQ-016 On start in IDLE, cfg_th/cfg_tl SHALL be captured into shadow registers, with 0 clamped to 1.
REQ-017 On start, counters SHALL clear, min_pass_off SHALL go to all-ones, off_cur SHALL load th-1, exp SHALL load ~d, and the state SHALL go to LOW.
REQ-018 LOW SHALL hold g=0 for exactly tl cycles, with d unchanged, then enter HIGH.
REQ-019 HIGH SHALL hold g=1 for exactly th cycles, indexed k=th-1 down to 0.
REQ-020 During HIGH, d SHALL equal exp in every cycle with k<=off_cur, so d is stable for off_cur+1 cycles before g falls.
REQ-021 SAMPLE SHALL last one cycle with g=0, d held, and q compared against exp.
REQ-022 In SAMPLE, a match SHALL increment pass_cnt and set min_pass_off=off_cur; a mismatch SHALL increment fail_cnt.
REQ-023 After SAMPLE, if off_cur==0 the state SHALL go to DONE.
REQ-024 After SAMPLE, if off_cur!=0, off_cur SHALL decrement, exp SHALL invert, and the state SHALL go to LOW.
REQ-025 Each sweep SHALL run exactly th trials of (tl+th+1) cycles each.
REQ-026 DONE SHALL assert done for one cycle and then return to IDLE; results SHALL hold until the next start.
REQ-027 busy SHALL be 1 in LOW, HIGH, SAMPLE and DONE, and 0 in IDLE.
REQ-028 start while busy SHALL be ignored.
REQ-029 abort in any non-IDLE state SHALL force IDLE at the next edge with g=0 and no done pulse; counters SHALL keep their partial values.
REQ-030 abort and start asserted together in IDLE: abort SHALL win, and the block SHALL stay in IDLE.
REQ-031 q SHALL be sampled without a synchronizer; integration SHALL guarantee that latch delays are shorter than one clk period.

Reset
REQ-032 While reset_L=0, the block SHALL immediately force state=IDLE, g=0, d=0, busy=0, done=0, pass_cnt=0, fail_cnt=0, min_pass_off=all-ones, and clear shadow registers.
REQ-033 Reset asserted mid-sweep SHALL abandon the sweep with no done pulse.

Structure
REQ-034 A shared package SHALL hold the state enumeration and the default W.
REQ-035 A single sub-module, gate_cycle_counter, SHALL provide the loadable down-counter used for the LOW and HIGH widths.

Verification
REQ-036 Ideal latch model, th=4, tl=3: start -> 4 trials of 8 cycles each, done 32 cycles after start, pass_cnt=4, fail_cnt=0, min_pass_off=0.
REQ-037 Latch model whose q lags d by 2 cycles, th=4, tl=3: offsets 3, 2, 1 pass and offset 0 fails -> pass_cnt=3, fail_cnt=1, min_pass_off=1.
REQ-038 th=0, tl=0 -> clamped to 1/1: a single trial of 3 cycles with g high for one cycle, then done.
REQ-039 abort during the second HIGH phase -> g=0 and busy=0 next cycle, no done, pass_cnt=1.
REQ-040 reset_L pulsed low between edges mid-LOW -> all outputs at reset values before the next edge; a later start runs a full sweep normally.
REQ-041 start re-asserted while busy, and start+abort together in IDLE -> no restart and no state change.
